// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-line instruction cache responder between fetch and the memory bus.
// Optional hit/miss counters are compiled in with the ICACHE_STATS_EN macro.
module icache_responder #(
    parameter int NUM_LINES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        proc2Imem_req,
    input  logic [31:0] proc2Imem_addr,
    output logic [31:0] Imem2proc_data,
    output logic        Imem2proc_valid,
    input  logic        icache_flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
`ifdef ICACHE_STATS_EN
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
`endif
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [TAG_W-1:0]     tag_d  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES];
    logic [31:0]          data_d [NUM_LINES];
    logic [31:0]          miss_addr_q, miss_addr_d;
    logic [31:0]          resp_data_q, resp_data_d;

    logic [IDX_W-1:0]     req_idx;
    logic [TAG_W-1:0]     req_tag;
    logic [IDX_W-1:0]     fill_idx;
    logic [TAG_W-1:0]     fill_tag;
    logic                 hit;
    logic                 fill_we;
    logic                 hit_evt;
    logic                 miss_evt;
    logic                 unused_addr_bits;

    assign req_idx  = proc2Imem_addr[IDX_W+1:2];
    assign req_tag  = proc2Imem_addr[31:IDX_W+2];
    assign fill_idx = miss_addr_q[IDX_W+1:2];
    assign fill_tag = miss_addr_q[31:IDX_W+2];
    assign hit      = proc2Imem_req && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign mem_addr = {miss_addr_q[31:2], 2'b00};

    // Byte offsets never select anything: lines hold a single word.
    assign unused_addr_bits = ^{proc2Imem_addr[1:0], miss_addr_q[1:0]};

    // Memory handshake: mem_req stays high with a stable mem_addr for the whole
    // MISS state; a cycle with mem_ack high completes the fill, and mem_ack seen
    // in any other state is ignored.
    always_comb begin
        state_d         = state_q;
        valid_d         = valid_q;
        miss_addr_d     = miss_addr_q;
        resp_data_d     = resp_data_q;
        fill_we         = 1'b0;
        hit_evt         = 1'b0;
        miss_evt        = 1'b0;
        mem_req         = 1'b0;
        Imem2proc_valid = 1'b0;
        Imem2proc_data  = 32'h0;

        case (state_q)
            IDLE: begin
                if (hit) begin
                    Imem2proc_valid = 1'b1;
                    Imem2proc_data  = data_q[req_idx];
                    hit_evt         = 1'b1;
                end else if (proc2Imem_req) begin
                    miss_addr_d = proc2Imem_addr;
                    miss_evt    = 1'b1;
                    state_d     = MISS;
                end
            end
            MISS: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    fill_we     = 1'b1;
                    resp_data_d = mem_rdata;
                    state_d     = RESP;
                end
            end
            RESP: begin
                // A redirected fetch gets nothing here; it is looked up again in IDLE.
                if (proc2Imem_req && (proc2Imem_addr[31:2] == miss_addr_q[31:2])) begin
                    Imem2proc_valid = 1'b1;
                    Imem2proc_data  = resp_data_q;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (fill_we) begin
            valid_d[fill_idx] = 1'b1;
        end
        // Flush overrides a coincident fill so the line comes back invalid.
        if (icache_flush) begin
            valid_d = '0;
        end
    end

    always_comb begin
        tag_d  = tag_q;
        data_d = data_q;
        if (fill_we) begin
            tag_d[fill_idx]  = fill_tag;
            data_d[fill_idx] = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            miss_addr_q <= 32'h0;
            resp_data_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            miss_addr_q <= miss_addr_d;
            resp_data_q <= resp_data_d;
        end
    end

    // Tag/data contents are qualified by valid_q, so they need no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q + {31'd0, hit_evt};
        miss_count_d = miss_count_q + {31'd0, miss_evt};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_q  <= 32'h0;
            miss_count_q <= 32'h0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    logic unused_stat_evts;
    assign unused_stat_evts = hit_evt ^ miss_evt;
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Randomized bench for icache_responder: a line-level cache model predicts hits and fills,
// a scoreboard queue holds expected responses and a negedge monitor checks them.
module tb_icache_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        proc2Imem_req = 1'b0;
    logic [31:0] proc2Imem_addr = 32'h0;
    logic [31:0] Imem2proc_data;
    logic        Imem2proc_valid;
    logic        icache_flush = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache_responder dut (
        .clk            (clk),
        .rst            (rst),
        .proc2Imem_req  (proc2Imem_req),
        .proc2Imem_addr (proc2Imem_addr),
        .Imem2proc_data (Imem2proc_data),
        .Imem2proc_valid(Imem2proc_valid),
        .icache_flush   (icache_flush),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
`ifdef ICACHE_STATS_EN
        .hit_count      (hit_count),
        .miss_count     (miss_count),
`endif
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];   // {cycle, expected word}

    // Reference cache: 16 lines, index = word address mod 16, tag = word address / 16.
    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_data  [16];
    int          m_hits   = 0;
    int          m_misses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst) begin
            if (exp_q.size() > 0 && int'(exp_q[0][63:32]) == cyc) begin
                e = exp_q.pop_front();
                check("resp_valid", {31'b0, Imem2proc_valid}, 32'd1);
                check("resp_data", Imem2proc_data, e[31:0]);
            end else begin
                check("no_resp_valid", {31'b0, Imem2proc_valid}, 32'd0);
                check("no_resp_data_zero", Imem2proc_data, 32'h0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One fetch transaction: request a, and on a miss serve the fill after dly cycles with rdata.
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] rdata, input int dly,
                            input bit branch, input logic [31:0] baddr,
                            input bit flush_req, input bit flush_ack);
        int          idx;
        logic [25:0] tg;
        idx = int'(a[5:2]);
        tg  = a[31:6];
        proc2Imem_req  = 1'b1;
        proc2Imem_addr = a;
        icache_flush   = flush_req;
        check("idle_mem_req_low", {31'b0, mem_req}, 32'd0);
        if (m_valid[idx] && m_tag[idx] == tg) begin
            exp_q.push_back({cyc[31:0], m_data[idx]});
            m_hits++;
            if (flush_req) model_clear();
            step();
            icache_flush = 1'b0;
            return;
        end
        m_misses++;
        if (flush_req) model_clear();
        step();
        icache_flush = 1'b0;
        if (branch) proc2Imem_addr = baddr;
        for (int d = 0; d < dly; d++) begin
            check("miss_mem_req", {31'b0, mem_req}, 32'd1);
            check("miss_mem_addr", mem_addr, {a[31:2], 2'b00});
            step();
        end
        check("ack_mem_req", {31'b0, mem_req}, 32'd1);
        check("ack_mem_addr", mem_addr, {a[31:2], 2'b00});
        mem_ack      = 1'b1;
        mem_rdata    = rdata;
        icache_flush = flush_ack;
        if (flush_ack) begin
            model_clear();
        end else begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_data[idx]  = rdata;
        end
        step();
        mem_ack      = 1'b0;
        icache_flush = 1'b0;
        mem_rdata    = $urandom;
        if (proc2Imem_addr[31:2] == a[31:2]) exp_q.push_back({cyc[31:0], rdata});
        check("resp_mem_req_low", {31'b0, mem_req}, 32'd0);
        step();
    endtask

    // Idle cycle with no request; optional stray ack and flush.
    task automatic do_idle(input bit ack, input bit flush);
        proc2Imem_req = 1'b0;
        mem_ack       = ack;
        mem_rdata     = $urandom;
        icache_flush  = flush;
        if (flush) model_clear();
        check("idle_mem_req", {31'b0, mem_req}, 32'd0);
        step();
        mem_ack      = 1'b0;
        icache_flush = 1'b0;
    endtask

    task automatic do_reset_cycle();
        rst           = 1'b1;
        proc2Imem_req = 1'b0;
        step();
        rst = 1'b0;
        model_clear();
        exp_q.delete();
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic reset_mid_fill(input logic [31:0] a);
        proc2Imem_req  = 1'b1;
        proc2Imem_addr = a;
        step();
        check("pre_rst_mem_req", {31'b0, mem_req}, 32'd1);
        do_reset_cycle();
        check("post_rst_mem_req", {31'b0, mem_req}, 32'd0);
        do_idle(1'b1, 1'b0);   // late ack must be ignored
    endtask

    task automatic check_stats(input string tag);
`ifdef ICACHE_STATS_EN
        check({tag, "_hit_count"}, hit_count, m_hits);
        check({tag, "_miss_count"}, miss_count, m_misses);
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
        return a;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] a;
        logic [31:0] b;
        bit          br;
        model_clear();
        step();
        do_reset_cycle();
        check("reset_mem_req", {31'b0, mem_req}, 32'd0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_valid", {31'b0, Imem2proc_valid}, 32'd0);
        check("reset_data", Imem2proc_data, 32'h0);
        check_stats("reset");

        // cold miss with a 3-cycle ack, then a same-cycle hit
        do_fetch(32'h0, 32'hDEADBEEF, 3, 0, 0, 0, 0);
        do_fetch(32'h0, 32'h0, 0, 0, 0, 0, 0);

        // conflict eviction on index 0
        do_idle(0, 1);
        do_fetch(32'h0,  32'h11111111, 0, 0, 0, 0, 0);
        do_fetch(32'h40, 32'h22222222, 1, 0, 0, 0, 0);
        do_fetch(32'h0,  32'h11111111, 0, 0, 0, 0, 0);

        // branch during miss
        do_fetch(32'h8,   32'h88888888, 2, 1, 32'h100, 0, 0);
        do_fetch(32'h100, 32'h01000100, 1, 0, 0, 0, 0);
        do_fetch(32'h8,   32'h0, 0, 0, 0, 0, 0);

        // flush invalidates everything
        do_fetch(32'h4, 32'h44444444, 0, 0, 0, 0, 0);
        do_idle(0, 1);
        do_fetch(32'h0, 32'h33333333, 0, 0, 0, 0, 0);
        do_fetch(32'h4, 32'h55555555, 2, 0, 0, 0, 0);

        // ack coincident with flush: returned but not kept
        do_fetch(32'hC, 32'h0000CCCC, 1, 0, 0, 0, 1);
        do_fetch(32'hC, 32'h0000C0C0, 0, 0, 0, 0, 0);

        // hit in the flush cycle is still reported
        do_fetch(32'hC, 32'h0, 0, 0, 0, 1, 0);
        do_fetch(32'hC, 32'h0000C1C1, 0, 0, 0, 0, 0);

        // reset in the middle of a fill
        reset_mid_fill(32'h0);
        do_fetch(32'h0, 32'h5555AAAA, 1, 0, 0, 0, 0);

        // byte offset ignored
        do_fetch(32'h0, 32'h0, 0, 0, 0, 0, 0);
        do_fetch(32'h3, 32'h0, 0, 0, 0, 0, 0);
        check_stats("byte_offset");

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            a  = rand_addr();
            br = ($urandom_range(0, 5) == 0);
            b  = rand_addr();
            if ($urandom_range(0, 7) == 0) begin
                do_idle($urandom_range(0, 1), ($urandom_range(0, 3) == 0));
            end else begin
                do_fetch(a, $urandom, $urandom_range(0, 3), br, b,
                         ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
            end
        end

        proc2Imem_req = 1'b0;
        step();
        step();
        check("queue_drained", exp_q.size(), 32'd0);
        check_stats("final");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
